// File: rtl/cache_fill_fsm_if.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm_if
// Description : Bundle of the lookup, main-memory and array-write signals that
//               connect a cache fill controller to its environment.
// Revision    : 1.0 - initial release
// ============================================================================
interface cache_fill_fsm_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int IDX_W  = 3
);
    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              memory_data_valid;
    logic [DATA_W-1:0] memory_data;
    logic              fsm_busy;
    logic              mem_req;
    logic [ADDR_W-1:0] memory_address;
    logic              write_data_array;
    logic              write_tag_array;
    logic [IDX_W-1:0]  fill_word_idx;
    logic [DATA_W-1:0] fill_data;

    // Controller side
    modport master (
        input  miss_detected,
        input  miss_address,
        input  memory_data_valid,
        input  memory_data,
        output fsm_busy,
        output mem_req,
        output memory_address,
        output write_data_array,
        output write_tag_array,
        output fill_word_idx,
        output fill_data
    );

    // Cache lookup / memory / array side
    modport slave (
        output miss_detected,
        output miss_address,
        output memory_data_valid,
        output memory_data,
        input  fsm_busy,
        input  mem_req,
        input  memory_address,
        input  write_data_array,
        input  write_tag_array,
        input  fill_word_idx,
        input  fill_data
    );
endinterface
`default_nettype wire

// File: rtl/cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : cache_fill_fsm
// Description : Cache-miss block fill controller. Issues one word read per
//               cycle to a pipelined in-order main memory, writes each
//               returned word to the data array and commits the tag with the
//               last word. fsm_busy stalls the pipeline while filling.
// Revision    : 1.0 - initial release
// ============================================================================
module cache_fill_fsm #(
    parameter int ADDR_W   = 16,
    parameter int DATA_W   = 16,
    parameter int WORDS    = 8,
    parameter int BYTE_OFF = 1
) (
    input  wire logic          clk,
    input  wire logic          rst,
    cache_fill_fsm_if.master   bus
);

    localparam int IDX_W      = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int c_BLK_BITS = $clog2(WORDS) + BYTE_OFF;

    // Clears the word-within-block and byte-within-word address bits
    localparam logic [ADDR_W-1:0] c_BLK_MASK =
        ~((ADDR_W'(1) << c_BLK_BITS) - ADDR_W'(1));

    // Counters carry one extra bit so that WORDS itself is representable
    localparam logic [IDX_W:0] c_WORDS   = (IDX_W+1)'(WORDS);
    localparam logic [IDX_W:0] c_LAST    = (IDX_W+1)'(WORDS - 1);
    localparam logic [IDX_W:0] c_CNT_ONE = (IDX_W+1)'(1);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_FILL = 1'b1
    } state_t;

    state_t            r_state;
    logic [IDX_W:0]    r_issueCnt;
    logic [IDX_W:0]    r_recvCnt;
    logic [ADDR_W-1:0] r_base;

    logic              w_issuing;
    logic              w_accept;
    logic              w_lastWord;
    logic [ADDR_W-1:0] w_offset;

    assign w_issuing  = (r_state == ST_FILL) && (r_issueCnt < c_WORDS);
    assign w_accept   = (r_state == ST_FILL) && bus.memory_data_valid;
    assign w_lastWord = (r_recvCnt == c_LAST);
    // Offset stays inside the block, so adding it to the base never carries out
    assign w_offset   = ADDR_W'(r_issueCnt) << BYTE_OFF;

    // Fill sequencing: latch the block base on a miss, count requests and responses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_issueCnt <= '0;
            r_recvCnt  <= '0;
            r_base     <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (bus.miss_detected) begin
                        r_base     <= bus.miss_address & c_BLK_MASK;
                        r_issueCnt <= '0;
                        r_recvCnt  <= '0;
                        r_state    <= ST_FILL;
                    end
                end
                ST_FILL: begin
                    // Requests and responses advance independently in the same cycle
                    if (w_issuing) begin
                        r_issueCnt <= r_issueCnt + c_CNT_ONE;
                    end
                    if (bus.memory_data_valid) begin
                        r_recvCnt <= r_recvCnt + c_CNT_ONE;
                        if (w_lastWord) begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Output decode; everything is held low while reset is asserted
    always_comb begin
        bus.fsm_busy         = 1'b0;
        bus.mem_req          = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.write_tag_array  = 1'b0;
        bus.fill_word_idx    = '0;
        bus.fill_data        = '0;
        if (!rst) begin
            // Busy asserts in the miss cycle itself so the stall is immediate
            bus.fsm_busy = (r_state == ST_FILL) || bus.miss_detected;
            bus.mem_req  = w_issuing;
            if (w_issuing) begin
                bus.memory_address = r_base + w_offset;
            end
            if (w_accept) begin
                bus.write_data_array = 1'b1;
                bus.fill_word_idx    = r_recvCnt[IDX_W-1:0];
                bus.fill_data        = bus.memory_data;
                bus.write_tag_array  = w_lastWord;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_fill_fsm.sv
`default_nettype none
// ============================================================================
// Module      : tb_cache_fill_fsm
// Description : Bench for cache_fill_fsm. Instance A (WORDS=4, 16-bit) is
//               checked every cycle against a queue-based fill model plus
//               literal expectations; instance B (WORDS=1, 32-bit data,
//               BYTE_OFF=2) is checked with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cache_fill_fsm;

    localparam int WORDS_A  = 4;
    localparam int STRIDE_A = 2;

    logic clk;
    logic rst;

    cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(16), .IDX_W(2)) busA ();
    cache_fill_fsm_if #(.ADDR_W(16), .DATA_W(32), .IDX_W(1)) busB ();

    cache_fill_fsm #(.ADDR_W(16), .DATA_W(16), .WORDS(4), .BYTE_OFF(1)) u_dutA (
        .clk (clk),
        .rst (rst),
        .bus (busA)
    );

    cache_fill_fsm #(.ADDR_W(16), .DATA_W(32), .WORDS(1), .BYTE_OFF(2)) u_dutB (
        .clk (clk),
        .rst (rst),
        .bus (busB)
    );

    int nChecks = 0;
    int nErrors = 0;
    int cyc     = 0;

    // Memory model state for instance A
    logic [15:0] addrQ[$];
    int          readyQ[$];
    int          lat        = 4;
    logic        gapEn      = 1'b0;
    logic        forceValid = 1'b0;
    int          fillNo     = 0;

    // Next-cycle inputs for instance B
    logic        nbMiss  = 1'b0;
    logic [15:0] nbAddr  = '0;
    logic        nbValid = 1'b0;
    logic [31:0] nbData  = '0;

    // Fill model for instance A
    logic        mFill = 1'b0;
    logic [15:0] reqQ[$];
    int          idxQ[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [15:0] memData(input logic [15:0] addr);
        return 16'(32'hA000 + (fillNo << 4) + ((32'(addr) >> 1) & 3));
    endfunction

    // One clock cycle: apply inputs after the edge, return just after the falling edge
    task automatic step(input logic r, input logic m, input logic [15:0] a);
        @(posedge clk);
        #1;
        cyc++;
        rst                    = r;
        busA.miss_detected     = m;
        busA.miss_address      = a;
        busA.memory_data_valid = 1'b0;
        busA.memory_data       = 16'($urandom);
        if (forceValid) begin
            busA.memory_data_valid = 1'b1;
        end else if (!r && addrQ.size() > 0 && readyQ[0] <= cyc &&
                     (!gapEn || $urandom_range(0, 1) == 1)) begin
            busA.memory_data_valid = 1'b1;
            busA.memory_data       = memData(addrQ.pop_front());
            void'(readyQ.pop_front());
        end
        busB.miss_detected     = nbMiss;
        busB.miss_address      = nbAddr;
        busB.memory_data_valid = nbValid;
        busB.memory_data       = nbData;
        @(negedge clk);
        #1;
    endtask

    task automatic waitIdle(input int bound);
        int n;
        n = 0;
        while (mFill && n < bound) begin
            step(1'b0, 1'b0, 16'h0);
            n++;
        end
        chk("fill_done", 32'(mFill), 32'd0);
    endtask

    // Pipelined in-order memory: capture each request with its due cycle
    always @(negedge clk) begin
        if (rst) begin
            addrQ.delete();
            readyQ.delete();
        end else if (busA.mem_req) begin
            addrQ.push_back(busA.memory_address);
            readyQ.push_back(cyc + lat);
        end
    end

    // Per-cycle comparison of instance A against the fill model
    always @(negedge clk) begin : p_check
        logic        eBusy;
        logic        eReq;
        logic        eWr;
        logic        eTag;
        logic [15:0] eAddr;
        logic [15:0] base;
        int          eIdx;
        eBusy = 1'b0;
        eReq  = 1'b0;
        eWr   = 1'b0;
        eTag  = 1'b0;
        eAddr = '0;
        eIdx  = 0;
        if (rst) begin
            mFill = 1'b0;
            reqQ.delete();
            idxQ.delete();
        end else if (!mFill) begin
            eBusy = busA.miss_detected;
            if (busA.miss_detected) begin
                base  = busA.miss_address & ~(16'(WORDS_A * STRIDE_A) - 16'd1);
                mFill = 1'b1;
                reqQ.delete();
                idxQ.delete();
                for (int i = 0; i < WORDS_A; i++) begin
                    reqQ.push_back(base + 16'(i * STRIDE_A));
                    idxQ.push_back(i);
                end
            end
        end else begin
            eBusy = 1'b1;
            if (reqQ.size() > 0) begin
                eReq  = 1'b1;
                eAddr = reqQ.pop_front();
            end
            if (busA.memory_data_valid && idxQ.size() > 0) begin
                eWr  = 1'b1;
                eIdx = idxQ.pop_front();
                eTag = (idxQ.size() == 0);
                if (eTag) mFill = 1'b0;
            end
        end
        chk("busy",       32'(busA.fsm_busy),         32'(eBusy));
        chk("mem_req",    32'(busA.mem_req),          32'(eReq));
        chk("data_write", 32'(busA.write_data_array), 32'(eWr));
        chk("tag_write",  32'(busA.write_tag_array),  32'(eTag));
        if (eReq) chk("mem_addr", 32'(busA.memory_address), 32'(eAddr));
        if (eWr) begin
            chk("fill_idx",  32'(busA.fill_word_idx), 32'(eIdx));
            chk("fill_data", 32'(busA.fill_data),     32'(busA.memory_data));
        end
    end

    initial begin
        rst = 1'b1;
        busA.miss_detected = 1'b0; busA.miss_address = '0;
        busA.memory_data_valid = 1'b0; busA.memory_data = '0;
        busB.miss_detected = 1'b0; busB.miss_address = '0;
        busB.memory_data_valid = 1'b0; busB.memory_data = '0;

        // Reset with random inputs, then valid pulses while idle
        for (int i = 0; i < 2; i++) begin
            nbMiss = 1'($urandom); nbAddr = 16'($urandom);
            nbValid = 1'($urandom); nbData = $urandom;
            forceValid = 1'($urandom);
            step(1'b1, 1'($urandom), 16'($urandom));
            chk("rst_busyA", 32'(busA.fsm_busy), 32'd0);
            chk("rst_reqA",  32'(busA.mem_req),  32'd0);
            chk("rst_busyB", 32'(busB.fsm_busy), 32'd0);
            chk("rst_wrB",   32'(busB.write_data_array), 32'd0);
        end
        nbMiss = 1'b0; nbValid = 1'b0;
        forceValid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b0, 16'h0);
            chk("idle_valid_wr", 32'(busA.write_data_array), 32'd0);
        end
        forceValid = 1'b0;
        step(1'b0, 1'b0, 16'h0);
        chk("idle_busyB", 32'(busB.fsm_busy), 32'd0);

        // Fixed latency 4, miss at 0x1236
        fillNo = 0; lat = 4; gapEn = 1'b0;
        step(1'b0, 1'b1, 16'h1236);
        chk("miss_busy", 32'(busA.fsm_busy), 32'd1);
        chk("miss_req",  32'(busA.mem_req),  32'd0);
        for (int k = 1; k <= 9; k++) begin
            step(1'b0, 1'b0, 16'h0);
            if (k <= 4) begin
                chk("lit_req",  32'(busA.mem_req), 32'd1);
                chk("lit_addr", 32'(busA.memory_address), 32'h1230 + 32'((k - 1) * 2));
            end else if (k <= 8) begin
                chk("lit_wr",   32'(busA.write_data_array), 32'd1);
                chk("lit_idx",  32'(busA.fill_word_idx), 32'(k - 5));
                chk("lit_data", 32'(busA.fill_data), 32'hA000 + 32'(k - 5));
                chk("lit_tag",  32'(busA.write_tag_array), 32'(k == 8));
            end else begin
                chk("lit_done_busy", 32'(busA.fsm_busy), 32'd0);
            end
        end

        // Random response gaps
        fillNo = 1; lat = 2; gapEn = 1'b1;
        step(1'b0, 1'b1, 16'h5A4C);
        waitIdle(80);
        gapEn = 1'b0;
        step(1'b0, 1'b0, 16'h0);

        // Miss pulses during FILL are ignored; back-to-back miss after completion
        fillNo = 2; lat = 3;
        step(1'b0, 1'b1, 16'h0F10);
        for (int n = 0; n < 60 && mFill; n++) begin
            step(1'b0, 1'($urandom_range(0, 1)), 16'($urandom));
        end
        chk("ignore_done", 32'(mFill), 32'd0);
        fillNo = 3;
        step(1'b0, 1'b1, 16'h2222);
        chk("b2b_busy", 32'(busA.fsm_busy), 32'd1);
        waitIdle(40);

        // Reset after two of four words, then a clean fill at 0x0008
        fillNo = 4; lat = 4;
        step(1'b0, 1'b1, 16'h3000);
        for (int n = 0; n < 40 && idxQ.size() > 2; n++) begin
            step(1'b0, 1'b0, 16'h0);
        end
        chk("two_written", 32'(idxQ.size()), 32'd2);
        step(1'b1, 1'b0, 16'h0);
        chk("rst_fill_tag", 32'(busA.write_tag_array), 32'd0);
        step(1'b0, 1'b0, 16'h0);
        chk("post_rst_busy", 32'(busA.fsm_busy), 32'd0);
        chk("post_rst_tag",  32'(busA.write_tag_array), 32'd0);
        fillNo = 5; lat = 1;
        step(1'b0, 1'b1, 16'h0008);
        for (int k = 1; k <= 4; k++) begin
            step(1'b0, 1'b0, 16'h0);
            chk("refill_addr", 32'(busA.memory_address), 32'h0008 + 32'((k - 1) * 2));
        end
        waitIdle(20);

        // Single-word block on instance B
        nbMiss = 1'b1; nbAddr = 16'h0107;
        step(1'b0, 1'b0, 16'h0);
        chk("b_miss_busy", 32'(busB.fsm_busy), 32'd1);
        nbMiss = 1'b0; nbAddr = 16'h0;
        step(1'b0, 1'b0, 16'h0);
        chk("b_req",  32'(busB.mem_req), 32'd1);
        chk("b_addr", 32'(busB.memory_address), 32'h0104);
        step(1'b0, 1'b0, 16'h0);
        chk("b_req_once", 32'(busB.mem_req),  32'd0);
        chk("b_busy_wait", 32'(busB.fsm_busy), 32'd1);
        nbValid = 1'b1; nbData = 32'hDEADBEEF;
        step(1'b0, 1'b0, 16'h0);
        chk("b_wr",   32'(busB.write_data_array), 32'd1);
        chk("b_tag",  32'(busB.write_tag_array),  32'd1);
        chk("b_idx",  32'(busB.fill_word_idx),    32'd0);
        chk("b_data", busB.fill_data,             32'hDEADBEEF);
        nbValid = 1'b0; nbData = 32'h0;
        step(1'b0, 1'b0, 16'h0);
        chk("b_done_busy", 32'(busB.fsm_busy), 32'd0);
        chk("b_done_wr",   32'(busB.write_data_array), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Parametrised cache-miss fill controller for the instruction and data caches in the 5-stage pipeline. On a miss it fetches a whole aligned block from a pipelined, fixed-order main memory. It issues one word request per cycle and writes each returned word into the data array. It commits the tag on the final word and holds fsm_busy so the hazard unit stalls the affected stage.

Parameters:
ADDR_W, 16, address width in bits
DATA_W, 16, word width in bits
WORDS, 8, words per block; power of two, >= 1
BYTE_OFF, 1, log2(bytes per word); word address stride is 1<<BYTE_OFF
IDX_W, max(1, log2(WORDS)), derived; width of the word index

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
miss_detected  in  1  cache lookup missed this cycle
miss_address  in  ADDR_W  address that missed
memory_data_valid  in  1  main memory returns a word this cycle
memory_data  in  DATA_W  returned word
fsm_busy  out  1  fill in progress; stall request
mem_req  out  1  read request to main memory this cycle
memory_address  out  ADDR_W  request address, valid when mem_req=1
write_data_array  out  1  write fill_data into the data array this cycle
write_tag_array  out  1  write tag/valid for the block this cycle
fill_word_idx  out  IDX_W  word index within block for the data write
fill_data  out  DATA_W  word to write (equals memory_data)

Behaviour:
- Clocking and reset: single clock clk. Reset rst is synchronous and active-high; all state updates on the rising edge.
- Reset: state=IDLE and issue_cnt=recv_cnt=0. base=0. All outputs are 0 in the cycle after reset.
- Main memory shares rst, so no stale responses survive a reset.
- Counters are IDX_W+1 bits wide, so the count WORDS is representable.
- Block base = miss_address with the low log2(WORDS)+BYTE_OFF bits cleared. Word addresses never cross the block, and no carry out of the block is possible.
- IDLE:
  - fsm_busy = miss_detected (combinational, same cycle as the miss).
  - mem_req=0.
  - On miss_detected: latch base, clear both counters, go to FILL.
  - memory_data_valid in IDLE is ignored: no array writes.
- FILL:
  - fsm_busy=1.
  - mem_req=1 while issue_cnt<WORDS. memory_address = base + (issue_cnt<<BYTE_OFF). issue_cnt increments each such cycle, so requests are back-to-back.
  - The first request goes out in the first FILL cycle, i.e. the cycle after the miss.
  - On memory_data_valid: write_data_array=1, fill_word_idx=recv_cnt[IDX_W-1:0], fill_data=memory_data; recv_cnt increments.
  - Responses arrive in request order with arbitrary latency and gaps. An issue and a response in the same cycle are independent.
  - On the valid for recv_cnt==WORDS-1: write_tag_array=1 in the same cycle, then go to IDLE. fsm_busy is 0 the next cycle unless a new miss_detected is present.
  - miss_detected during FILL is ignored; there is no queuing.
- Outputs write_data_array, write_tag_array, fill_word_idx, fill_data and fsm_busy are combinational from state and inputs. mem_req and memory_address come from state only.
- WORDS=1: a single request; tag and data are written on the same valid.
- rst during FILL: return to IDLE next cycle. No tag write occurs; partially written data is harmless because the tag stays invalid.

Test Plan:
- Reset: hold rst 2 cycles with random inputs -> all outputs 0. Valid pulses while idle -> no write_data_array.
- WORDS=4, fixed memory latency 4, miss_address=0x1236 -> fsm_busy=1 same cycle. mem_req cycles 1-4 with addresses 0x1230, 0x1232, 0x1234, 0x1236. Writes idx 0..3 with returned data (0xA000..0xA003) in cycles 5-8. write_tag_array=1 with idx 3. fsm_busy=0 in cycle 9.
- Response gaps: same fill with memory_data_valid deasserted randomly -> every word written exactly once in index order. Tag written only with the 4th word.
- Extra miss_detected pulses during FILL -> no restart, base unchanged. A miss asserted the cycle after completion starts a new fill with fsm_busy=1 immediately.
- rst asserted after 2 of 4 words -> IDLE the next cycle, no write_tag_array. A following miss at 0x0008 fills 0x0008..0x000E correctly.
- WORDS=1, DATA_W=32, BYTE_OFF=2, miss 0x0107 -> a single request to 0x0104. Data and tag written on the same valid cycle.
